// File: rtl/pm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pm_ctrl_if
// Brief    : Fetch-port and boot-loader signal bundle for pm_ctrl.
// Revision : 1.0
// ============================================================================
interface pm_ctrl_if #(
    parameter int PM_AW = 10
);
    logic              ps_pm_cslt;
    logic              ps_pm_wrb;
    logic [15:0]       ps_pm_add;
    logic [31:0]       ps_pm_dt;
    logic [31:0]       pm_ps_op;
    logic              ld_start;
    logic              ld_vld;
    logic              ld_last;
    logic [31:0]       ld_dt;
    logic              ld_rdy;
    logic [PM_AW:0]    ld_cnt;
    logic              pm_busy;
    logic              pm_err;

    modport master (
        output ps_pm_cslt, ps_pm_wrb, ps_pm_add, ps_pm_dt,
        output ld_start, ld_vld, ld_last, ld_dt,
        input  pm_ps_op, ld_rdy, ld_cnt, pm_busy, pm_err
    );

    modport slave (
        input  ps_pm_cslt, ps_pm_wrb, ps_pm_add, ps_pm_dt,
        input  ld_start, ld_vld, ld_last, ld_dt,
        output pm_ps_op, ld_rdy, ld_cnt, pm_busy, pm_err
    );
endinterface
`default_nettype wire

// File: rtl/pm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pm_ctrl
// Brief    : Program-memory responder with boot-load FSM. Optional macro
//            PM_WRITE_EN enables sequencer writes to the RAM while in RUN.
// Revision : 1.0
// ============================================================================
module pm_ctrl #(
    parameter int          PM_AW  = 10,
    parameter logic [31:0] PM_NOP = 32'h0000_0000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pm_ctrl_if.slave   bus
);
    localparam int             c_DEPTH    = 1 << PM_AW;
    localparam logic [PM_AW:0] c_LAST_IDX = (PM_AW + 1)'(c_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_mem [c_DEPTH];
    logic [PM_AW:0]     r_ld_cnt;
    logic [31:0]        r_op;
    logic               r_err;
    logic               w_accept;
    logic               w_oor;
    logic               w_ld_rdy;
    logic               w_busy;
    logic               w_we;
    logic [PM_AW-1:0]   w_waddr;
    logic [31:0]        w_wdata;

    // A restart request takes precedence over a word offered in the same cycle.
    assign w_accept = (r_state == S_LOAD) && bus.ld_vld && !bus.ld_start;
    assign w_oor    = |(bus.ps_pm_add >> PM_AW);

    always_comb begin
        w_state_nxt = r_state;
        w_ld_rdy    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.ld_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ld_rdy = 1'b1;
                if (bus.ld_start)
                    w_state_nxt = S_LOAD;
                else if (w_accept && (bus.ld_last || r_ld_cnt == c_LAST_IDX))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b0;
                if (bus.ld_start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single RAM write port: loader owns it in LOAD, sequencer (if enabled) in RUN.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ld_cnt[PM_AW-1:0];
        w_wdata = bus.ld_dt;
        if (w_accept) begin
            w_we = 1'b1;
        end
`ifdef PM_WRITE_EN
        else if (r_state == S_RUN && bus.ps_pm_cslt && bus.ps_pm_wrb && !w_oor) begin
            w_we    = 1'b1;
            w_waddr = bus.ps_pm_add[PM_AW-1:0];
            w_wdata = bus.ps_pm_dt;
        end
`endif
    end

`ifndef PM_WRITE_EN
    logic w_unused_dt;
    assign w_unused_dt = ^bus.ps_pm_dt;
`endif

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ld_cnt <= '0;
            r_op     <= PM_NOP;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= 1'b0;
            if (bus.ld_start)
                r_ld_cnt <= '0;
            else if (w_accept)
                r_ld_cnt <= r_ld_cnt + 1'b1;

            // cslt low leaves the last instruction in place for a stalled sequencer.
            if (bus.ps_pm_cslt) begin
                if (r_state != S_RUN || w_oor) begin
                    r_op  <= PM_NOP;
                    r_err <= 1'b1;
                end else if (bus.ps_pm_wrb) begin
`ifdef PM_WRITE_EN
                    r_op  <= r_op;
`else
                    r_op  <= PM_NOP;
                    r_err <= 1'b1;
`endif
                end else begin
                    r_op <= r_mem[bus.ps_pm_add[PM_AW-1:0]];
                end
            end
        end
    end

    assign bus.pm_ps_op = r_op;
    assign bus.pm_err   = r_err;
    assign bus.ld_rdy   = w_ld_rdy;
    assign bus.ld_cnt   = r_ld_cnt;
    assign bus.pm_busy  = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_pm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pm_ctrl
// Brief    : Directed self-checking bench for pm_ctrl with a fetch scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pm_ctrl;
    localparam int c_AW = 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [32:0] exp_q [$];

    pm_ctrl_if #(.PM_AW(c_AW)) bus ();

    pm_ctrl #(.PM_AW(c_AW), .PM_NOP(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sequencer access: expectation queued at drive time, checked when the word appears.
    task automatic access(input string tag, input logic wrb, input logic [15:0] addr,
                          input logic [31:0] dt, input logic [31:0] exp_op, input logic exp_err);
        logic [32:0] e;
        bus.ps_pm_cslt = 1'b1;
        bus.ps_pm_wrb  = wrb;
        bus.ps_pm_add  = addr;
        bus.ps_pm_dt   = dt;
        exp_q.push_back({exp_err, exp_op});
        tick();
        bus.ps_pm_cslt = 1'b0;
        bus.ps_pm_wrb  = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_op"},  bus.pm_ps_op, e[31:0]);
        chk({tag, "_err"}, {31'd0, bus.pm_err}, {31'd0, e[32]});
    endtask

    initial begin
        logic [31:0] words [4];
        n_cmp = 0;
        n_bad = 0;
        words[0] = 32'hC000_1111;
        words[1] = 32'hC000_2222;
        words[2] = 32'hC000_3333;
        words[3] = 32'hC000_4444;
        bus.ps_pm_cslt = 1'b0;
        bus.ps_pm_wrb  = 1'b0;
        bus.ps_pm_add  = 16'h0;
        bus.ps_pm_dt   = 32'h0;
        bus.ld_start   = 1'b0;
        bus.ld_vld     = 1'b0;
        bus.ld_last    = 1'b0;
        bus.ld_dt      = 32'h0;

        rst = 1'b0;
        tick();
        tick();
        chk("rst_op",   bus.pm_ps_op, 32'h0);
        chk("rst_busy", {31'd0, bus.pm_busy}, 32'd1);
        chk("rst_rdy",  {31'd0, bus.ld_rdy}, 32'd0);
        chk("rst_cnt",  {21'd0, bus.ld_cnt}, 32'd0);
        chk("rst_err",  {31'd0, bus.pm_err}, 32'd0);
        rst = 1'b1;
        tick();

        access("idle_fetch", 1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
        chk("idle_busy", {31'd0, bus.pm_busy}, 32'd1);

        // Four-word image with ld_last on the final word.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("load_rdy", {31'd0, bus.ld_rdy}, 32'd1);
        chk("load_cnt0", {21'd0, bus.ld_cnt}, 32'd0);
        access("load_fetch", 1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.ld_vld  = 1'b1;
            bus.ld_dt   = words[i];
            bus.ld_last = (i == 3);
            tick();
            chk("load4_cnt", {21'd0, bus.ld_cnt}, i + 1);
        end
        bus.ld_vld  = 1'b0;
        bus.ld_last = 1'b0;
        chk("load4_busy", {31'd0, bus.pm_busy}, 32'd0);
        chk("load4_rdy",  {31'd0, bus.ld_rdy}, 32'd0);

        for (int i = 0; i < 4; i++)
            access("run_fetch", 1'b0, 16'(i), 32'h0, words[i], 1'b0);

        access("stall_fetch", 1'b0, 16'h0002, 32'h0, 32'hC000_3333, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_op",  bus.pm_ps_op, 32'hC000_3333);
            chk("stall_err", {31'd0, bus.pm_err}, 32'd0);
        end

        // Full-depth image without ld_last.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("reload_cnt0", {21'd0, bus.ld_cnt}, 32'd0);
        bus.ld_vld = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            bus.ld_dt = 32'hA500_0000 | i;
            tick();
            if (i == 511) begin
                chk("full_mid_cnt", {21'd0, bus.ld_cnt}, 32'd512);
                chk("full_mid_rdy", {31'd0, bus.ld_rdy}, 32'd1);
            end
        end
        chk("full_cnt",  {21'd0, bus.ld_cnt}, 32'd1024);
        chk("full_rdy",  {31'd0, bus.ld_rdy}, 32'd0);
        chk("full_busy", {31'd0, bus.pm_busy}, 32'd0);
        bus.ld_dt = 32'h1234_5678;
        tick();
        chk("full_hold_cnt", {21'd0, bus.ld_cnt}, 32'd1024);
        bus.ld_vld = 1'b0;

        access("top_addr", 1'b0, 16'h03FF, 32'h0, 32'hA500_03FF, 1'b0);
        access("addr0",    1'b0, 16'h0000, 32'h0, 32'hA500_0000, 1'b0);
        access("oor_400",  1'b0, 16'h0400, 32'h0, 32'h0, 1'b1);
        access("oor_8000", 1'b0, 16'h8000, 32'h0, 32'h0, 1'b1);
        access("pre_wr",   1'b0, 16'h0003, 32'h0, 32'hA500_0003, 1'b0);
`ifdef PM_WRITE_EN
        access("wr5",      1'b1, 16'h0005, 32'hDEAD_BEEF, 32'hA500_0003, 1'b0);
        access("rd5",      1'b0, 16'h0005, 32'h0, 32'hDEAD_BEEF, 1'b0);
`else
        access("wr5",      1'b1, 16'h0005, 32'hDEAD_BEEF, 32'h0, 1'b1);
        access("rd5",      1'b0, 16'h0005, 32'h0, 32'hA500_0005, 1'b0);
`endif
        access("oor_wr",   1'b1, 16'h0405, 32'h5555_AAAA, 32'h0, 1'b1);
        access("rd5_b",    1'b0, 16'h0005, 32'h0,
`ifdef PM_WRITE_EN
               32'hDEAD_BEEF,
`else
               32'hA500_0005,
`endif
               1'b0);

        // Reset in the middle of a reload.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_vld   = 1'b1;
        bus.ld_dt    = 32'h7777_0000;
        tick();
        bus.ld_dt    = 32'h7777_0001;
        tick();
        bus.ld_vld   = 1'b0;
        chk("mid_cnt", {21'd0, bus.ld_cnt}, 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_op",   bus.pm_ps_op, 32'h0);
        chk("mid_rst_busy", {31'd0, bus.pm_busy}, 32'd1);
        chk("mid_rst_rdy",  {31'd0, bus.ld_rdy}, 32'd0);
        chk("mid_rst_cnt",  {21'd0, bus.ld_cnt}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        access("post_rst_fetch", 1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
